// File: rtl/par_frame_pkg.sv
// Shared types and line levels for the parity-framing serial transmitter.
package par_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/par_frame_tx_if.sv
// Producer-side word handshake plus serial line and status of par_frame_tx.
interface par_frame_tx_if #(parameter int DATA_W = 4);
    import par_frame_pkg::*;

    // A word transfers on a rising edge where din_valid && din_ready are both 1;
    // the producer must hold din stable while din_valid=1 and din_ready=0.
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              tx_out;
    logic              tx_busy;
    logic              frame_done;
    logic              frame_par;
    state_e            fsm_state;

    modport master (
        output din, din_valid,
        input  din_ready, tx_out, tx_busy, frame_done, frame_par, fsm_state
    );

    modport slave (
        input  din, din_valid,
        output din_ready, tx_out, tx_busy, frame_done, frame_par, fsm_state
    );

endinterface

// File: rtl/par_gen_n.sv
// Even-parity generator: appends the XOR of the payload as the frame LSB.
module par_gen_n #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W:0]   dout,
    output logic              parity
);

    assign parity = ^din;
    assign dout   = {din, parity};

endmodule

// File: rtl/par_frame_tx.sv
// Serial frame transmitter: start bit, payload MSB first, even parity, stop bit.
module par_frame_tx
    import par_frame_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    par_frame_tx_if.slave bus
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W:0]     shift_q, shift_d;
    logic                tx_out_q, tx_out_d;
    logic                tx_busy_q, tx_busy_d;
    logic                frame_done_q, frame_done_d;
    logic                par_q, par_d;
    logic [DATA_W:0]     gen_dout;
    logic                gen_parity;
    logic                din_ready;
    logic                baud_end;

    par_gen_n #(.DATA_W(DATA_W)) u_par_gen (
        .din    (bus.din),
        .dout   (gen_dout),
        .parity (gen_parity)
    );

    assign din_ready = (state_q == IDLE) && !rst;
    assign baud_end  = (baud_cnt_q == BAUD_LAST);

    // Outputs are computed for the state being entered so they stay registered.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_out_d     = tx_out_q;
        tx_busy_d    = tx_busy_q;
        par_d        = par_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.din_valid && din_ready) begin
                    state_d    = START;
                    shift_d    = gen_dout;
                    par_d      = gen_parity;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_out_d   = START_LVL;
                    tx_busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    tx_out_d   = shift_q[DATA_W];
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_out_d  = STOP_LVL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q << 1;
                        tx_out_d  = shift_q[DATA_W-1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d      = IDLE;
                    baud_cnt_d   = '0;
                    tx_out_d     = IDLE_LVL;
                    tx_busy_d    = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_out_q     <= IDLE_LVL;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
            par_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_out_q     <= tx_out_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
            par_q        <= par_d;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.tx_out     = tx_out_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_par  = par_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_par_frame_tx.sv
// Bench for par_frame_tx: two instances (BAUD_DIV 1 and 3) against a bit-list frame model.
module tb_par_frame_tx;
    import par_frame_pkg::*;

    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    par_frame_tx_if #(.DATA_W(DW)) bus1 ();
    par_frame_tx_if #(.DATA_W(DW)) bus3 ();

    par_frame_tx #(.DATA_W(DW), .BAUD_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    par_frame_tx #(.DATA_W(DW), .BAUD_DIV(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx(input int sel);
        return (sel == 3) ? bus3.tx_out : bus1.tx_out;
    endfunction
    function automatic logic busy(input int sel);
        return (sel == 3) ? bus3.tx_busy : bus1.tx_busy;
    endfunction
    function automatic logic done(input int sel);
        return (sel == 3) ? bus3.frame_done : bus1.frame_done;
    endfunction
    function automatic logic rdy(input int sel);
        return (sel == 3) ? bus3.din_ready : bus1.din_ready;
    endfunction
    function automatic logic fpar(input int sel);
        return (sel == 3) ? bus3.frame_par : bus1.frame_par;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [DW-1:0] w);
        if (sel == 3) begin
            bus3.din_valid = v;
            bus3.din       = w;
        end else begin
            bus1.din_valid = v;
            bus1.din       = w;
        end
    endtask

    // Reference frame: list of line levels, each repeated baud times.
    function automatic logic model_parity(input logic [DW-1:0] w);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(w[i]);
        return logic'(ones % 2);
    endfunction

    function automatic void build(input logic [DW-1:0] w, input int baud);
        logic bits[$];
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = DW - 1; i >= 0; i--) bits.push_back(w[i]);
        bits.push_back(model_parity(w));
        bits.push_back(1'b1);
        foreach (bits[k]) for (int r = 0; r < baud; r++) exp_q.push_back(bits[k]);
    endfunction

    task automatic accept(input int sel, input logic [DW-1:0] w, input logic hold, input logic [DW-1:0] w_next);
        int t = 0;
        @(negedge clk);
        drive(sel, 1'b1, w);
        while (!rdy(sel) && t < 64) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", rdy(sel), 1'b1);
        @(posedge clk);
        #1;
        if (hold) drive(sel, 1'b1, w_next);
        else drive(sel, 1'b0, ~w);
    endtask

    task automatic check_frame(input int sel, input logic [DW-1:0] w, input int baud, input string tag);
        int n;
        logic e;
        build(w, baud);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s_tx%0d", tag, i), tx(sel), e);
            check($sformatf("%s_busy%0d", tag, i), busy(sel), 1'b1);
            check($sformatf("%s_done%0d", tag, i), done(sel), 1'b0);
            check($sformatf("%s_rdy%0d", tag, i), rdy(sel), 1'b0);
            if (i == 0) check($sformatf("%s_par", tag), fpar(sel), model_parity(w));
        end
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), done(sel), 1'b1);
        check($sformatf("%s_end_busy", tag), busy(sel), 1'b0);
        check($sformatf("%s_end_tx", tag), tx(sel), 1'b1);
        check($sformatf("%s_end_rdy", tag), rdy(sel), 1'b1);
    endtask

    initial begin
        logic [DW-1:0] w;
        rst = 1'b1;
        drive(1, 1'b0, '0);
        drive(3, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx1", tx(1), 1'b1);
        check("rst_busy1", busy(1), 1'b0);
        check("rst_done1", done(1), 1'b0);
        check("rst_rdy1", rdy(1), 1'b0);
        check("rst_state1", 8'(bus1.fsm_state), 8'(IDLE));
        check("rst_tx3", tx(3), 1'b1);
        check("rst_rdy3", rdy(3), 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy1", rdy(1), 1'b1);
        check("post_rst_rdy3", rdy(3), 1'b1);

        // Directed words at BAUD_DIV=1 and 3.
        accept(1, 4'b0011, 1'b0, '0);
        check_frame(1, 4'b0011, 1, "b1_0011");
        accept(1, 4'b1011, 1'b0, '0);
        check_frame(1, 4'b1011, 1, "b1_1011");
        accept(1, 4'b1111, 1'b0, '0);
        check_frame(1, 4'b1111, 1, "b1_1111");
        accept(3, 4'b0011, 1'b0, '0);
        check_frame(3, 4'b0011, 3, "b3_0011");

        // Valid held with a new word during a frame, then taken on the done cycle.
        accept(1, 4'b0110, 1'b1, 4'b1001);
        check_frame(1, 4'b0110, 1, "bp_first");
        @(posedge clk);
        #1 drive(1, 1'b0, 4'b0000);
        check_frame(1, 4'b1001, 1, "bp_second");

        // Reset on cycle 3 of a frame.
        accept(1, 4'b1011, 1'b0, '0);
        @(negedge clk);
        check("mid_c1_tx", tx(1), 1'b0);
        @(negedge clk);
        check("mid_c2_tx", tx(1), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        check("mid_rdy_in_rst", rdy(1), 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_tx", tx(1), 1'b1);
        check("mid_rst_busy", busy(1), 1'b0);
        check("mid_rst_rdy", rdy(1), 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("mid_after_done%0d", i), done(1), 1'b0);
            check($sformatf("mid_after_tx%0d", i), tx(1), 1'b1);
            check($sformatf("mid_after_rdy%0d", i), rdy(1), 1'b1);
        end

        for (int k = 0; k < 6; k++) begin
            w = DW'($urandom_range(0, 15));
            accept(1, w, 1'b0, '0);
            check_frame(1, w, 1, $sformatf("rnd1_%0d", k));
        end
        for (int k = 0; k < 3; k++) begin
            w = DW'($urandom_range(0, 15));
            accept(3, w, 1'b0, '0);
            check_frame(3, w, 3, $sformatf("rnd3_%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
